bcd_to_bin_seq: RTL
===================

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 4 BCD digits in and 14 bits out.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a conversion; sampled only in IDLE.
REQ-005 bcd3  input  4  thousands digit.
REQ-006 bcd2  input  4  hundreds digit.
REQ-007 bcd1  input  4  tens digit.
REQ-008 bcd0  input  4  ones digit.
REQ-009 ready  output  1  high in IDLE; start is accepted only when ready=1.
REQ-010 busy  output  1  high in CHECK and SHIFT.
REQ-011 done  output  1  one-cycle pulse; bin and err are valid in that cycle.
REQ-012 err  output  1  last request held a digit >9; held until the next accepted start.
REQ-013 bin  output  14  binary result (0..9999); held until the next accepted start.

Function
REQ-014 The FSM SHALL have the states IDLE, CHECK, SHIFT and DONE, with ready=(IDLE), busy=(CHECK|SHIFT) and done=(DONE).
REQ-015 IDLE with start=1 SHALL capture all four digits into a 30-bit work register {bcd3,bcd2,bcd1,bcd0,14'b0}, clear err and bin, and go to CHECK.
REQ-016 IDLE with start=0 SHALL hold state and all outputs.
REQ-017 CHECK with any captured digit >9 SHALL set err=1, keep bin=0 and go to DONE without shifting.
REQ-018 CHECK with all captured digits valid SHALL clear the iteration counter and go to SHIFT.
REQ-019 Each SHIFT cycle SHALL shift the work register right by 1, then subtract 3 from each of the four 4-bit BCD fields whose value is >=8 (reverse double-dabble).
REQ-020 After exactly 14 SHIFT cycles, the block SHALL load bin from work[13:0] and go to DONE.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-022 Valid-input latency SHALL be 16 cycles: start sampled at edge N gives done high in the cycle after edge N+15.
REQ-023 Invalid-input latency SHALL be 2 cycles: done high in the cycle after edge N+1.
REQ-024 start in CHECK, SHIFT or DONE SHALL be ignored; it is neither queued nor able to alter the in-flight conversion.
REQ-025 Input digits SHALL be sampled only at acceptance; later input changes SHALL not affect the result.
REQ-026 The iteration counter SHALL be 4 bits wide, count 0..13, and never wrap during a conversion.
REQ-027 Arithmetic SHALL be unsigned with no overflow: a valid input never leaves any BCD field negative after the subtract-3 step.
REQ-028 Back-to-back operation: start held high SHALL be accepted again in the IDLE cycle after DONE, giving a throughput of one conversion per 17 cycles.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, counter=0, work=0, bin=0, err=0, done=0, busy=0, ready=1, overriding start.
REQ-030 rst asserted mid-conversion SHALL abort it with no done pulse, and the next start after release SHALL convert normally.

Structure
REQ-031 A shared package bcd_pkg SHALL hold the following constants and typedef:
- state enum (IDLE, CHECK, SHIFT, DONE);
- BCD_DIGITS=4, BIN_W=14, ITER_CNT=14;
- MAX_DIGIT=9.
REQ-032 One sub-module bcd_digit_adj SHALL implement the per-digit adjustment (4-bit in -> in>=8 ? in-3 : in) and be instantiated four times.
REQ-033 The module SHALL contain no other sub-modules and no latches.

Verification
REQ-034 Digits 9,9,9,9 with start -> done 16 cycles later, bin=9999, err=0.
REQ-035 Digits 0,0,0,0 -> bin=0, err=0; digits 1,2,3,4 -> bin=1234; digits 0,0,0,8 -> bin=8.
REQ-036 Digits 0,0,0xA,0 -> done 2 cycles after start, err=1, bin=0; a following conversion of 0,0,4,2 gives err=0, bin=42.
REQ-037 start pulsed again and all inputs changed during SHIFT -> result equals the originally captured value, and exactly one done pulse occurs.
REQ-038 rst asserted at iteration 7 of a conversion of 5,6,7,8 -> no done, all outputs at reset values; a restart gives bin=5678.
REQ-039 Exhaustive sweep 0..9999 in BCD with start held high -> every bin equals the decimal value, err=0, and done pulses are spaced 17 cycles apart.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit helper for the BCD-to-binary converter.
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

   localparam int BCD_DIGITS = 4;
   localparam int BIN_W      = 14;
   localparam int ITER_CNT   = 14;
   localparam int MAX_DIGIT  = 9;
   localparam int WORK_W     = BCD_DIGITS * 4 + BIN_W;

   function automatic logic digit_bad(input logic [3:0] d);
      return d > 4'(MAX_DIGIT);
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD field: subtract 3 when the field is 8 or more.
module bcd_digit_adj (
   input  logic [3:0] digit,
   output logic [3:0] adj
);

   assign adj = (digit >= 4'd8) ? digit - 4'd3 : digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential 4-digit BCD to 14-bit binary converter using reverse double-dabble,
// one shift per clock, with digit validity check before shifting.
module bcd_to_bin_seq
   import bcd_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        bcd3,
   input  logic [3:0]        bcd2,
   input  logic [3:0]        bcd1,
   input  logic [3:0]        bcd0,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [BIN_W-1:0]  bin
);

   state_t            state;
   logic [3:0]        cnt;
   logic [WORK_W-1:0] work;
   logic [WORK_W-1:0] shifted;
   logic [WORK_W-1:0] next_work;

   assign shifted              = work >> 1;
   assign next_work[BIN_W-1:0] = shifted[BIN_W-1:0];

   // BCD fields sit above the binary accumulator; each is corrected after the shift.
   for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit (shifted[BIN_W + 4*d +: 4]),
         .adj   (next_work[BIN_W + 4*d +: 4])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         work  <= '0;
         bin   <= '0;
         err   <= 1'b0;
         done  <= 1'b0;
         busy  <= 1'b0;
         ready <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  work  <= {bcd3, bcd2, bcd1, bcd0, {BIN_W{1'b0}}};
                  err   <= 1'b0;
                  bin   <= '0;
                  ready <= 1'b0;
                  busy  <= 1'b1;
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (digit_bad(work[29:26]) || digit_bad(work[25:22]) ||
                   digit_bad(work[21:18]) || digit_bad(work[17:14])) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               work <= next_work;
               if (cnt == 4'(ITER_CNT - 1)) begin
                  bin   <= next_work[BIN_W-1:0];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
